burst_grant_scheduler: RTL and testbench
========================================

BURST_GRANT_SCHEDULER -- requirements
Module: burst_grant_scheduler

Interface
REQ-001 Parameter N, default 4, number of requesters (N >= 2, need not be a power of two).
REQ-002 Parameter MAX_BEATS, default 16, maximum beats per burst before forced release (MAX_BEATS >= 1).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  block enable; gates new grants only.
REQ-006 req  input  N  per-requester request, level-sensitive, held until granted burst ends.
REQ-007 beat  input  1  shared resource accepted one beat from the current owner this cycle.
REQ-008 last  input  1  the beat presented with beat=1 is the final beat of the owner's burst; ignored when beat=0.
REQ-009 gnt  output  N  one-hot grant to the current owner, all-zero when no owner; registered.
REQ-010 gnt_id  output  clog2(N)  binary index of the current owner, 0 when gnt is zero; registered.
REQ-011 busy  output  1  high in GRANT and RELEASE states.
REQ-012 timeout  output  1  one-cycle pulse when a burst is cut at MAX_BEATS without last.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-014 The block SHALL hold a priority pointer ptr (clog2(N) bits, range 0..N-1) naming the highest-priority requester.
REQ-015 IDLE: if en=1 and req!=0, select the first set req bit scanning ptr, ptr+1, ... wrapping N-1 -> 0; register it into gnt/gnt_id; go to GRANT.
REQ-016 IDLE with en=0 or req=0: stay in IDLE, gnt=0.
REQ-017 Grant latency SHALL be one cycle: req seen in IDLE at edge t yields gnt valid after edge t (visible in cycle t+1).
REQ-018 GRANT: beat counter cnt (clog2(MAX_BEATS)+1 bits) starts at 0 and increments on every beat=1.
REQ-019 GRANT -> RELEASE on beat=1 and last=1; timeout=0.
REQ-020 GRANT -> RELEASE on beat=1, last=0 and cnt==MAX_BEATS-1; timeout pulses for one cycle (the RELEASE cycle).
REQ-021 GRANT -> RELEASE when req[gnt_id]=0 and beat=0 (owner abandons); timeout=0.
REQ-022 If beat=1 and last=1 coincide with cnt==MAX_BEATS-1, this is a normal end; timeout SHALL stay 0.
REQ-023 en=0 during GRANT SHALL NOT affect the current burst.
REQ-024 RELEASE: gnt=0 and gnt_id=0 for exactly one cycle (dead cycle); ptr <= (last owner + 1) mod N; cnt <= 0; go to IDLE.
REQ-025 ptr SHALL change only on leaving RELEASE; otherwise it holds.
REQ-026 gnt SHALL never have more than one bit set, and SHALL change only on RELEASE entry or IDLE exit.
REQ-027 Back-to-back bursts: minimum gap between two grants is two cycles (RELEASE, then IDLE arbitration).

Reset
REQ-028 While reset=0 at a posedge: state=IDLE, ptr=0, cnt=0, gnt=0, gnt_id=0, busy=0, timeout=0.
REQ-029 Reset asserted mid-burst SHALL clear gnt on the next edge with no RELEASE cycle and no ptr update.
REQ-030 First arbitration after reset SHALL favour requester 0.

Verification
REQ-031 After reset, req=4'b1010, en=1 -> gnt=4'b0010, gnt_id=1 one cycle later; after beat+last, RELEASE cycle with gnt=0, then ptr=2, next grant 4'b1000.
REQ-032 All four req held continuously, each burst 2 beats ending in last -> grant order 0,1,2,3,0 with one RELEASE and one IDLE cycle between grants.
REQ-033 MAX_BEATS=16, owner 2 sends 16 beats with last=0 -> RELEASE after 16th beat, timeout=1 for one cycle, ptr=3.
REQ-034 Owner 1 drops req after 3 beats with beat=0 -> RELEASE next edge, timeout=0, ptr=2.
REQ-035 en=0 with req=4'b0001 -> gnt stays 0; en dropped during an active burst -> burst completes normally.
REQ-036 reset=0 mid-burst at beat 5 -> next cycle gnt=0, busy=0, ptr=0, cnt=0.

Source files
------------

// File: rtl/burst_grant_scheduler.sv
// Round-robin burst arbiter: grants one requester at a time for a burst of beats,
// with forced release at MAX_BEATS and a one-cycle dead cycle between owners.
module burst_grant_scheduler #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 beat,
    input  logic                 last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] id_nxt, pick_id;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  gnt_nxt;
    logic          tmo_nxt;
    logic          pick_found;
    int            idx;

    // First set request at or after ptr, wrapping at N (N need not be a power of two).
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!pick_found && req[idx[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    gnt_nxt   = N'(1) << pick_id;
                    id_nxt    = pick_id;
                    owner_nxt = pick_id;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    cnt_nxt = cnt + CW'(1);
                    if (last) begin
                        state_nxt = RELEASE;
                    end else if (cnt == CW'(MAX_BEATS - 1)) begin
                        state_nxt = RELEASE;
                        tmo_nxt   = 1'b1;
                    end
                end else if (!req[gnt_id]) begin
                    state_nxt = RELEASE;
                end
                if (state_nxt == RELEASE) begin
                    gnt_nxt = '0;
                    id_nxt  = '0;
                end
            end
            RELEASE: begin
                ptr_nxt   = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= id_nxt;
            timeout <= tmo_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_burst_grant_scheduler.sv
// Bench for burst_grant_scheduler: directed bursts with a queue of expected grant and
// release events, checked by a monitor that watches gnt edges.
module tb_burst_grant_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic       beat;
    logic       last;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // kind: 0 = grant, 1 = release (busy high), 2 = drop by reset (busy low)
    typedef struct {
        int         kind;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       tmo;
        int         gap;
    } ev_t;
    ev_t exp_q[$];

    burst_grant_scheduler #(.N(4), .MAX_BEATS(16)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .beat(beat), .last(last),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int id, input int gap);
        ev_t e;
        e.kind = 0; e.gnt = 4'(1 << id); e.id = 2'(id); e.tmo = 1'b0; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic exp_rel(input int kind, input logic tmo);
        ev_t e;
        e.kind = kind; e.gnt = 4'b0000; e.id = 2'd0; e.tmo = tmo; e.gap = -1;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic [3:0] prev_gnt = 4'b0000;
    int         cyc = 0;
    int         last_rel = 0;
    int         kind;
    ev_t        e;

    always @(negedge clk) begin
        cyc++;
        if (prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt)
            chk("gnt_switch_without_release", int'(gnt), int'(prev_gnt));
        if ((prev_gnt == 4'b0000) != (gnt == 4'b0000)) begin
            kind = (gnt != 4'b0000) ? 0 : (busy ? 1 : 2);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: actual kind=%0d gnt=%b required none", kind, gnt);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_gnt", int'(gnt), int'(e.gnt));
                chk("event_gnt_id", int'(gnt_id), int'(e.id));
                chk("event_timeout", int'(timeout), int'(e.tmo));
                if (kind == 0 && e.gap >= 0) chk("grant_gap", cyc - last_rel, e.gap);
                if (kind == 1) last_rel = cyc;
            end
        end else if (timeout) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_timeout: actual=1 required=0 at cycle %0d", cyc);
        end
        prev_gnt = gnt;
    end

    initial begin
        reset = 1'b0; en = 1'b0; req = 4'b0000; beat = 1'b0; last = 1'b0;
        step(2);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_ptr", int'(dut.ptr), 0);
        chk("rst_cnt", int'(dut.cnt), 0);
        reset = 1'b1;

        // Basic grant, release and pointer advance
        req = 4'b1010; en = 1'b1; exp_grant(1, -1);
        step(1);
        chk("latency_gnt", int'(gnt), 2);
        chk("latency_busy", int'(busy), 1);
        beat = 1'b1; last = 1'b1; exp_rel(1, 1'b0);
        step(1);
        chk("release_busy", int'(busy), 1);
        beat = 1'b0; last = 1'b0; req = 4'b1000; exp_grant(3, 2);
        step(1);
        chk("ptr_after_1", int'(dut.ptr), 2);
        chk("idle_busy", int'(busy), 0);
        step(1);
        chk("second_gnt", int'(gnt), 8);
        beat = 1'b1; last = 1'b1; exp_rel(1, 1'b0);
        step(1);
        beat = 1'b0; last = 1'b0; req = 4'b0000;
        step(1);

        // Round robin with all requests held, two-beat bursts
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_grant(k % 4, (k == 0) ? -1 : 2);
            exp_rel(1, 1'b0);
            step(1);
            chk("rr_gnt_id", int'(gnt_id), k % 4);
            beat = 1'b1; last = 1'b0;
            step(1);
            last = 1'b1;
            step(1);
            beat = 1'b0; last = 1'b0;
            if (k == 4) req = 4'b0000;
            step(1);
        end
        chk("rr_ptr_end", int'(dut.ptr), 1);

        // Forced release at MAX_BEATS
        req = 4'b0100; exp_grant(2, -1); exp_rel(1, 1'b1);
        step(1);
        beat = 1'b1;
        step(15);
        chk("no_early_cut", int'(gnt), 4);
        chk("cnt_at_15", int'(dut.cnt), 15);
        step(1);
        chk("timeout_pulse", int'(timeout), 1);
        beat = 1'b0; req = 4'b0000;
        step(1);
        chk("timeout_clears", int'(timeout), 0);
        chk("ptr_after_timeout", int'(dut.ptr), 3);

        // last on the MAX_BEATS-th beat is a normal end
        req = 4'b0001; exp_grant(0, -1); exp_rel(1, 1'b0);
        step(1);
        beat = 1'b1;
        step(15);
        last = 1'b1;
        step(1);
        chk("last_at_max_no_timeout", int'(timeout), 0);
        beat = 1'b0; last = 1'b0; req = 4'b0000;
        step(1);
        chk("ptr_after_max_last", int'(dut.ptr), 1);

        // Owner abandons after three beats
        req = 4'b0010; exp_grant(1, -1); exp_rel(1, 1'b0);
        step(1);
        beat = 1'b1;
        step(3);
        beat = 1'b0; req = 4'b0000;
        step(1);
        chk("abandon_busy", int'(busy), 1);
        step(1);
        chk("ptr_after_abandon", int'(dut.ptr), 2);

        // Enable gating
        en = 1'b0; req = 4'b0001;
        step(3);
        chk("en_low_no_gnt", int'(gnt), 0);
        chk("en_low_not_busy", int'(busy), 0);
        en = 1'b1; exp_grant(0, -1);
        step(1);
        en = 1'b0; beat = 1'b1;
        step(1);
        chk("en_drop_keeps_gnt", int'(gnt), 1);
        last = 1'b1; exp_rel(1, 1'b0);
        step(1);
        beat = 1'b0; last = 1'b0; req = 4'b0000;
        step(1);
        chk("ptr_after_en_burst", int'(dut.ptr), 1);

        // Reset mid-burst at beat 5
        en = 1'b1; req = 4'b0100; exp_grant(2, -1);
        step(1);
        beat = 1'b1;
        step(4);
        chk("cnt_before_reset", int'(dut.cnt), 4);
        reset = 1'b0; exp_rel(2, 1'b0);
        step(1);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ptr", int'(dut.ptr), 0);
        chk("midrst_cnt", int'(dut.cnt), 0);
        reset = 1'b1; beat = 1'b0; req = 4'b1001;
        exp_grant(0, -1); exp_rel(1, 1'b0);
        step(1);
        chk("post_reset_favours_0", int'(gnt_id), 0);
        req = 4'b0000;
        step(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
